// File: rtl/avst_video_gray_rx.sv
// Avalon-ST RGB888 video sink: parses the packet-type header, converts pixels to luma
// and always emits exactly IMAGE_WIDTH*IMAGE_HEIGHT pixels per frame on a valid/ready stream.
module avst_video_gray_rx #(
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int CNT_WIDTH    = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] din_data,
    input  logic        din_valid,
    input  logic        din_sop,
    input  logic        din_eop,
    output logic        din_ready,
    output logic [7:0]  pxl_out,
    output logic        valid_out,
    input  logic        dout_ready,
    output logic        frame_done,
    output logic        frame_err
);

    typedef enum logic [1:0] {IDLE, VIDEO, PAD, DRAIN} state_t;

    localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(IMAGE_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(IMAGE_HEIGHT - 1);

    state_t               state, state_next;
    logic [CNT_WIDTH-1:0] col, row;
    logic                 reg_free, last_pix;
    logic                 load, advance, clear_cnt, done_next, err_next;
    logic [7:0]           y_next;

    // Weights sum to 256, so the top byte of the 16-bit sum is already in range.
    function automatic logic [7:0] luma(input logic [23:0] rgb);
        logic [15:0] sum;
        sum = 16'(77) * 16'(rgb[23:16]) + 16'(150) * 16'(rgb[15:8]) + 16'(29) * 16'(rgb[7:0]);
        return sum[15:8];
    endfunction

    assign reg_free = !valid_out || dout_ready;
    assign last_pix = (col == COL_LAST) && (row == ROW_LAST);

    always_comb begin
        state_next = state;
        din_ready  = 1'b0;
        load       = 1'b0;
        advance    = 1'b0;
        y_next     = 8'd0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                din_ready = 1'b1;
                if (din_valid && din_sop) begin
                    if (din_data[3:0] == 4'd0) begin
                        if (din_eop) begin
                            state_next = PAD;
                            err_next   = 1'b1;
                        end else begin
                            state_next = VIDEO;
                        end
                    end else if (!din_eop) begin
                        state_next = DRAIN;
                    end
                end
            end
            VIDEO: begin
                // A new sop mid-frame is held off so IDLE can take it after padding.
                if (din_valid && din_sop) begin
                    state_next = PAD;
                    err_next   = 1'b1;
                end else begin
                    din_ready = reg_free;
                    if (din_valid && reg_free) begin
                        load    = 1'b1;
                        advance = 1'b1;
                        y_next  = luma(din_data);
                        if (last_pix) begin
                            done_next = 1'b1;
                            if (din_eop) begin
                                state_next = IDLE;
                            end else begin
                                err_next   = 1'b1;
                                state_next = DRAIN;
                            end
                        end else if (din_eop) begin
                            err_next   = 1'b1;
                            state_next = PAD;
                        end
                    end
                end
            end
            PAD: begin
                if (reg_free) begin
                    load    = 1'b1;
                    advance = 1'b1;
                    if (last_pix) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            DRAIN: begin
                din_ready = 1'b1;
                if (din_valid && din_eop) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (!reset_n) begin
            din_ready = 1'b0;
        end
        clear_cnt = (state_next == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clear_cnt) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pxl_out    <= 8'd0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (load) begin
                pxl_out   <= y_next;
                valid_out <= 1'b1;
            end else if (dout_ready) begin
                valid_out <= 1'b0;
            end
            frame_done <= done_next;
            frame_err  <= err_next;
        end
    end

endmodule
